// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - shared encodings for the pipelined RV32I decode stage
package id_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_LUI     = 4'd1,
        CLS_AUIPC   = 4'd2,
        CLS_JAL     = 4'd3,
        CLS_JALR    = 4'd4,
        CLS_BRANCH  = 4'd5,
        CLS_LOAD    = 4'd6,
        CLS_STORE   = 4'd7,
        CLS_ALU_IMM = 4'd8,
        CLS_ALU_REG = 4'd9,
        CLS_FENCE   = 4'd10,
        CLS_SYSTEM  = 4'd11
    } cls_e;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_KILL  = 2'd2
    } state_e;

endpackage

// File: rtl/id_decode.sv
// rtl/id_decode.sv - combinational RV32I opcode class, immediate and register-use decode
module id_decode
    import id_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_i,
    output logic [3:0]      cls_o,
    output logic [XLEN-1:0] imm_o,
    output logic            reg_we_o,
    output logic            is_load_o,
    output logic            rs1_used_o,
    output logic            rs2_used_o
);

    cls_e               cls;
    logic signed [31:0] imm32;

    always_comb begin
        cls = CLS_ILLEGAL;
        case (inst_i[6:0])
            OP_LUI:    cls = CLS_LUI;
            OP_AUIPC:  cls = CLS_AUIPC;
            OP_JAL:    cls = CLS_JAL;
            OP_JALR:   cls = CLS_JALR;
            OP_BRANCH: cls = CLS_BRANCH;
            OP_LOAD:   cls = CLS_LOAD;
            OP_STORE:  cls = CLS_STORE;
            OP_IMM:    cls = CLS_ALU_IMM;
            OP_REG:    cls = CLS_ALU_REG;
            OP_FENCE:  cls = CLS_FENCE;
            OP_SYSTEM: cls = CLS_SYSTEM;
            default:   cls = CLS_ILLEGAL;
        endcase
    end

    always_comb begin
        imm32 = '0;
        case (cls)
            CLS_JALR, CLS_LOAD, CLS_ALU_IMM, CLS_SYSTEM:
                imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            CLS_STORE:
                imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            CLS_BRANCH:
                imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
            CLS_LUI, CLS_AUIPC:
                imm32 = {inst_i[31:12], 12'b0};
            CLS_JAL:
                imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    // rd == x0 never counts as a write so it cannot trigger forwarding or hazards
    always_comb begin
        reg_we_o   = 1'b0;
        rs1_used_o = 1'b0;
        rs2_used_o = 1'b0;
        case (cls)
            CLS_LUI, CLS_AUIPC, CLS_JAL: reg_we_o = 1'b1;
            CLS_JALR, CLS_LOAD, CLS_ALU_IMM, CLS_SYSTEM: begin
                reg_we_o   = 1'b1;
                rs1_used_o = 1'b1;
            end
            CLS_ALU_REG: begin
                reg_we_o   = 1'b1;
                rs1_used_o = 1'b1;
                rs2_used_o = 1'b1;
            end
            CLS_BRANCH, CLS_STORE: begin
                rs1_used_o = 1'b1;
                rs2_used_o = 1'b1;
            end
            default: ;
        endcase
        if (inst_i[11:7] == 5'd0) reg_we_o = 1'b0;
    end

    assign cls_o     = cls;
    assign imm_o     = XLEN'(imm32);
    assign is_load_o = (cls == CLS_LOAD);

endmodule

// File: rtl/id_pipe.sv
// rtl/id_pipe.sv - pipelined RV32I decode stage with handshake, hazards, ID-resolved branches and kill
module id_pipe
    import id_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int PC_WORD_ADDR = 1,
    parameter int KILL_SLOTS   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid_i,
    input  logic [31:0]     if_inst_i,
    input  logic [XLEN-1:0] if_pc_i,
    output logic            id_ready_o,
    output logic [4:0]      reg1_addr_o,
    output logic [4:0]      reg2_addr_o,
    input  logic [XLEN-1:0] reg1_data_i,
    input  logic [XLEN-1:0] reg2_data_i,
    input  logic            ex_ready_i,
    output logic            ex_valid_o,
    output logic [XLEN-1:0] ex_pc_o,
    output logic [XLEN-1:0] ex_link_o,
    output logic [XLEN-1:0] ex_imm_o,
    output logic [XLEN-1:0] ex_rs1_data_o,
    output logic [XLEN-1:0] ex_rs2_data_o,
    output logic [4:0]      ex_rd_o,
    output logic [2:0]      ex_funct3_o,
    output logic            ex_alu30_o,
    output logic [3:0]      ex_class_o,
    output logic            ex_reg_we_o,
    output logic            ex_is_load_o,
    output logic [1:0]      ex_fwd_a_o,
    output logic [1:0]      ex_fwd_b_o,
    input  logic [4:0]      mem_rd_i,
    input  logic            mem_reg_we_i,
    input  logic            flush_i,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o
);

    localparam logic [XLEN-1:0] PC_STEP = (PC_WORD_ADDR != 0) ? XLEN'(1) : XLEN'(4);
    localparam logic [1:0]      KILL_INIT = 2'(KILL_SLOTS);

    logic [4:0]      rs1, rs2, rd;
    logic [2:0]      funct3;
    logic [3:0]      cls_w;
    cls_e            cls;
    logic [XLEN-1:0] imm;
    logic            reg_we, is_load, rs1_used, rs2_used;

    id_decode #(.XLEN(XLEN)) u_decode (
        .inst_i     (if_inst_i),
        .cls_o      (cls_w),
        .imm_o      (imm),
        .reg_we_o   (reg_we),
        .is_load_o  (is_load),
        .rs1_used_o (rs1_used),
        .rs2_used_o (rs2_used)
    );

    assign cls    = cls_e'(cls_w);
    assign rs1    = if_inst_i[19:15];
    assign rs2    = if_inst_i[24:20];
    assign rd     = if_inst_i[11:7];
    assign funct3 = if_inst_i[14:12];

    assign reg1_addr_o = rs1;
    assign reg2_addr_o = rs2;

    logic            ex_valid_q, ex_reg_we_q, ex_is_load_q, ex_alu30_q;
    logic [XLEN-1:0] ex_pc_q, ex_link_q, ex_imm_q, ex_rs1_data_q, ex_rs2_data_q;
    logic [4:0]      ex_rd_q;
    logic [2:0]      ex_funct3_q;
    logic [3:0]      ex_class_q;
    logic [1:0]      ex_fwd_a_q, ex_fwd_b_q;
    logic            redirect_valid_q;
    logic [XLEN-1:0] redirect_pc_q;
    state_e          state_q, state_d;
    logic [1:0]      kill_cnt_q, kill_cnt_d;

    logic adv, hazard, load_use, cmp_hit, is_cmp, id_ready, xfer, load_en, take;
    logic rs1_ex, rs2_ex, rs1_mem, rs2_mem;
    logic [1:0] fwd_a, fwd_b;

    assign adv = ex_ready_i | ~ex_valid_q;

    assign rs1_ex  = rs1_used & (rs1 != 5'd0) & ex_valid_q & ex_reg_we_q & (ex_rd_q == rs1);
    assign rs2_ex  = rs2_used & (rs2 != 5'd0) & ex_valid_q & ex_reg_we_q & (ex_rd_q == rs2);
    assign rs1_mem = rs1_used & (rs1 != 5'd0) & mem_reg_we_i & (mem_rd_i == rs1);
    assign rs2_mem = rs2_used & (rs2 != 5'd0) & mem_reg_we_i & (mem_rd_i == rs2);

    // ID-resolved compares read only regfile data, so any in-flight producer must drain first
    assign is_cmp   = (cls == CLS_BRANCH) | (cls == CLS_JALR);
    assign load_use = ex_is_load_q & (rs1_ex | rs2_ex);
    assign cmp_hit  = is_cmp & (rs1_ex | rs2_ex | rs1_mem | rs2_mem);
    assign hazard   = if_valid_i & (load_use | cmp_hit);

    assign fwd_a = (rs1_ex & ~ex_is_load_q) ? FWD_EX : (rs1_mem ? FWD_MEM : FWD_REG);
    assign fwd_b = (rs2_ex & ~ex_is_load_q) ? FWD_EX : (rs2_mem ? FWD_MEM : FWD_REG);

    logic [XLEN-1:0] br_off, jalr_sum, jalr_clr, target;

    always_comb begin
        take = 1'b0;
        case (cls)
            CLS_JAL, CLS_JALR: take = 1'b1;
            CLS_BRANCH: begin
                case (funct3)
                    F3_BEQ:  take = (reg1_data_i == reg2_data_i);
                    F3_BNE:  take = (reg1_data_i != reg2_data_i);
                    F3_BLT:  take = ($signed(reg1_data_i) <  $signed(reg2_data_i));
                    F3_BGE:  take = ($signed(reg1_data_i) >= $signed(reg2_data_i));
                    F3_BLTU: take = (reg1_data_i <  reg2_data_i);
                    F3_BGEU: take = (reg1_data_i >= reg2_data_i);
                    default: take = 1'b0;
                endcase
            end
            default: take = 1'b0;
        endcase
    end

    assign br_off   = (PC_WORD_ADDR != 0) ? XLEN'($signed(imm) >>> 2) : imm;
    assign jalr_sum = reg1_data_i + imm;
    assign jalr_clr = jalr_sum & ~XLEN'(1);
    assign target   = (cls == CLS_JALR) ? ((PC_WORD_ADDR != 0) ? (jalr_clr >> 2) : jalr_clr)
                                        : (if_pc_i + br_off);

    always_comb begin
        state_d    = state_q;
        kill_cnt_d = kill_cnt_q;
        id_ready   = 1'b0;
        if (flush_i) begin
            state_d    = ST_RUN;
            kill_cnt_d = 2'd0;
        end else begin
            case (state_q)
                ST_KILL: begin
                    id_ready = 1'b1;
                    if (if_valid_i) begin
                        kill_cnt_d = kill_cnt_q - 2'd1;
                        if (kill_cnt_q <= 2'd1) state_d = ST_RUN;
                    end
                end
                default: begin
                    id_ready = adv & ~hazard;
                    if (if_valid_i & id_ready & take & (KILL_SLOTS > 0)) begin
                        state_d    = ST_KILL;
                        kill_cnt_d = KILL_INIT;
                    end else begin
                        state_d = hazard ? ST_STALL : ST_RUN;
                    end
                end
            endcase
        end
    end

    assign id_ready_o = id_ready;
    assign xfer       = if_valid_i & id_ready;
    assign load_en    = xfer & (state_q != ST_KILL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_RUN;
            kill_cnt_q       <= 2'd0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            ex_valid_q       <= 1'b0;
            ex_pc_q          <= '0;
            ex_link_q        <= '0;
            ex_imm_q         <= '0;
            ex_rs1_data_q    <= '0;
            ex_rs2_data_q    <= '0;
            ex_rd_q          <= '0;
            ex_funct3_q      <= '0;
            ex_alu30_q       <= 1'b0;
            ex_class_q       <= '0;
            ex_reg_we_q      <= 1'b0;
            ex_is_load_q     <= 1'b0;
            ex_fwd_a_q       <= '0;
            ex_fwd_b_q       <= '0;
        end else begin
            state_q          <= state_d;
            kill_cnt_q       <= kill_cnt_d;
            redirect_valid_q <= load_en & take;
            if (load_en & take) redirect_pc_q <= target;
            if (flush_i) begin
                ex_valid_q <= 1'b0;
            end else if (adv) begin
                ex_valid_q <= load_en;
                if (load_en) begin
                    ex_pc_q       <= if_pc_i;
                    ex_link_q     <= if_pc_i + PC_STEP;
                    ex_imm_q      <= imm;
                    ex_rs1_data_q <= reg1_data_i;
                    ex_rs2_data_q <= reg2_data_i;
                    ex_rd_q       <= rd;
                    ex_funct3_q   <= funct3;
                    ex_alu30_q    <= if_inst_i[30];
                    ex_class_q    <= cls_w;
                    ex_reg_we_q   <= reg_we;
                    ex_is_load_q  <= is_load;
                    ex_fwd_a_q    <= fwd_a;
                    ex_fwd_b_q    <= fwd_b;
                end
            end
        end
    end

    assign ex_valid_o       = ex_valid_q;
    assign ex_pc_o          = ex_pc_q;
    assign ex_link_o        = ex_link_q;
    assign ex_imm_o         = ex_imm_q;
    assign ex_rs1_data_o    = ex_rs1_data_q;
    assign ex_rs2_data_o    = ex_rs2_data_q;
    assign ex_rd_o          = ex_rd_q;
    assign ex_funct3_o      = ex_funct3_q;
    assign ex_alu30_o       = ex_alu30_q;
    assign ex_class_o       = ex_class_q;
    assign ex_reg_we_o      = ex_reg_we_q;
    assign ex_is_load_o     = ex_is_load_q;
    assign ex_fwd_a_o       = ex_fwd_a_q;
    assign ex_fwd_b_o       = ex_fwd_b_q;
    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;

endmodule

// File: tb/tb_id_pipe.sv
// tb/tb_id_pipe.sv - directed self-checking bench for id_pipe in word- and byte-addressed builds
module tb_id_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid_i, ex_ready_i, mem_reg_we_i, flush_i;
    logic [31:0] if_inst_i, if_pc_i;
    logic [4:0]  mem_rd_i;
    logic [31:0] reg1_data_i, reg2_data_i;
    logic [31:0] regs [32];

    // word-addressed instance outputs
    logic        id_ready_w, ex_valid_w, ex_alu30_w, ex_reg_we_w, ex_is_load_w, redir_v_w;
    logic [4:0]  reg1_addr_w, reg2_addr_w, ex_rd_w;
    logic [31:0] ex_pc_w, ex_link_w, ex_imm_w, ex_rs1_w, ex_rs2_w, redir_pc_w;
    logic [2:0]  ex_funct3_w;
    logic [3:0]  ex_class_w;
    logic [1:0]  ex_fwd_a_w, ex_fwd_b_w;

    // byte-addressed instance outputs
    logic        id_ready_b, ex_valid_b, ex_alu30_b, ex_reg_we_b, ex_is_load_b, redir_v_b;
    logic [4:0]  reg1_addr_b, reg2_addr_b, ex_rd_b;
    logic [31:0] ex_pc_b, ex_link_b, ex_imm_b, ex_rs1_b, ex_rs2_b, redir_pc_b;
    logic [2:0]  ex_funct3_b;
    logic [3:0]  ex_class_b;
    logic [1:0]  ex_fwd_a_b, ex_fwd_b_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign reg1_data_i = regs[reg1_addr_w];
    assign reg2_data_i = regs[reg2_addr_w];

    id_pipe #(.XLEN(32), .PC_WORD_ADDR(1), .KILL_SLOTS(1)) u_dut_w (
        .clk(clk), .rst(rst), .if_valid_i(if_valid_i), .if_inst_i(if_inst_i), .if_pc_i(if_pc_i),
        .id_ready_o(id_ready_w), .reg1_addr_o(reg1_addr_w), .reg2_addr_o(reg2_addr_w),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i), .ex_ready_i(ex_ready_i),
        .ex_valid_o(ex_valid_w), .ex_pc_o(ex_pc_w), .ex_link_o(ex_link_w), .ex_imm_o(ex_imm_w),
        .ex_rs1_data_o(ex_rs1_w), .ex_rs2_data_o(ex_rs2_w), .ex_rd_o(ex_rd_w),
        .ex_funct3_o(ex_funct3_w), .ex_alu30_o(ex_alu30_w), .ex_class_o(ex_class_w),
        .ex_reg_we_o(ex_reg_we_w), .ex_is_load_o(ex_is_load_w), .ex_fwd_a_o(ex_fwd_a_w),
        .ex_fwd_b_o(ex_fwd_b_w), .mem_rd_i(mem_rd_i), .mem_reg_we_i(mem_reg_we_i),
        .flush_i(flush_i), .redirect_valid_o(redir_v_w), .redirect_pc_o(redir_pc_w)
    );

    id_pipe #(.XLEN(32), .PC_WORD_ADDR(0), .KILL_SLOTS(1)) u_dut_b (
        .clk(clk), .rst(rst), .if_valid_i(if_valid_i), .if_inst_i(if_inst_i), .if_pc_i(if_pc_i),
        .id_ready_o(id_ready_b), .reg1_addr_o(reg1_addr_b), .reg2_addr_o(reg2_addr_b),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i), .ex_ready_i(ex_ready_i),
        .ex_valid_o(ex_valid_b), .ex_pc_o(ex_pc_b), .ex_link_o(ex_link_b), .ex_imm_o(ex_imm_b),
        .ex_rs1_data_o(ex_rs1_b), .ex_rs2_data_o(ex_rs2_b), .ex_rd_o(ex_rd_b),
        .ex_funct3_o(ex_funct3_b), .ex_alu30_o(ex_alu30_b), .ex_class_o(ex_class_b),
        .ex_reg_we_o(ex_reg_we_b), .ex_is_load_o(ex_is_load_b), .ex_fwd_a_o(ex_fwd_a_b),
        .ex_fwd_b_o(ex_fwd_b_b), .mem_rd_i(mem_rd_i), .mem_reg_we_i(mem_reg_we_i),
        .flush_i(flush_i), .redirect_valid_o(redir_v_b), .redirect_pc_o(redir_pc_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        if_valid_i = v;
        if_inst_i  = inst;
        if_pc_i    = pc;
        #1;
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [12:0] off, input logic [2:0] f3);
        return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[1] = 32'h1;
        regs[2] = 32'h2;
        regs[5] = 32'h103;
        rst = 1'b1; if_valid_i = 0; if_inst_i = 0; if_pc_i = 0;
        ex_ready_i = 1'b1; mem_rd_i = 0; mem_reg_we_i = 0; flush_i = 0;
        tick(); tick();
        check("rst_ex_valid", 32'(ex_valid_w), 32'h0);
        check("rst_redir_v", 32'(redir_v_w), 32'h0);
        check("rst_redir_pc", redir_pc_w, 32'h0);
        check("rst_ex_pc", ex_pc_w, 32'h0);
        check("rst_ex_imm", ex_imm_w, 32'h0);
        rst = 1'b0;
        tick();

        // ADDI x1,x0,5 @0x10
        drive(1'b1, enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011), 32'h10);
        check("addi_ready", 32'(id_ready_w), 32'h1);
        tick();
        check("addi_valid", 32'(ex_valid_w), 32'h1);
        check("addi_imm", ex_imm_w, 32'h5);
        check("addi_rd", 32'(ex_rd_w), 32'h1);
        check("addi_link_w", ex_link_w, 32'h11);
        check("addi_link_b", ex_link_b, 32'h14);
        check("addi_no_redir", 32'(redir_v_w), 32'h0);

        // LW x2,0(x1): x1 produced by ADDI in EX
        drive(1'b1, enc_i(12'd0, 5'd1, 3'b010, 5'd2, 7'b0000011), 32'h11);
        tick();
        check("lw_is_load", 32'(ex_is_load_w), 32'h1);
        check("lw_fwd_a", 32'(ex_fwd_a_w), 32'h1);

        // ADD x3,x2,x2: load-use, one bubble, then MEM forwarding
        mem_rd_i = 5'd1; mem_reg_we_i = 1'b1;
        drive(1'b1, enc_r(5'd3, 5'd2, 5'd2), 32'h12);
        check("ld_use_ready", 32'(id_ready_w), 32'h0);
        tick();
        check("ld_use_bubble", 32'(ex_valid_w), 32'h0);
        mem_rd_i = 5'd2; mem_reg_we_i = 1'b1;
        #1;
        check("ld_use_resume", 32'(id_ready_w), 32'h1);
        tick();
        check("add_valid", 32'(ex_valid_w), 32'h1);
        check("add_rd", 32'(ex_rd_w), 32'h3);
        check("add_fwd_a", 32'(ex_fwd_a_w), 32'h2);
        check("add_fwd_b", 32'(ex_fwd_b_w), 32'h2);
        mem_rd_i = 5'd0; mem_reg_we_i = 1'b0;

        // BEQ x0,x0,+16 @0x20
        drive(1'b1, enc_b(5'd0, 5'd0, 13'd16, 3'b000), 32'h20);
        tick();
        check("beq_redir_v", 32'(redir_v_w), 32'h1);
        check("beq_redir_pc_w", redir_pc_w, 32'h24);
        check("beq_redir_pc_b", redir_pc_b, 32'h30);
        drive(1'b1, enc_i(12'd1, 5'd0, 3'b000, 5'd5, 7'b0010011), 32'h21);
        check("kill_ready", 32'(id_ready_w), 32'h1);
        tick();
        check("beq_pulse_end", 32'(redir_v_w), 32'h0);
        check("kill_discard", 32'(ex_valid_w), 32'h0);
        drive(1'b1, enc_i(12'd7, 5'd0, 3'b000, 5'd6, 7'b0010011), 32'h24);
        tick();
        check("post_kill_valid", 32'(ex_valid_w), 32'h1);
        check("post_kill_pc", ex_pc_w, 32'h24);

        // BNE x6,x0 while x6 is produced in EX: compare hazard
        drive(1'b1, enc_b(5'd6, 5'd0, 13'd8, 3'b001), 32'h25);
        check("cmp_haz_ready", 32'(id_ready_w), 32'h0);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("cmp_haz_bubble", 32'(ex_valid_w), 32'h0);

        // JALR x1,8(x5), x5=0x103
        drive(1'b1, enc_i(12'd8, 5'd5, 3'b000, 5'd1, 7'b1100111), 32'h40);
        tick();
        check("jalr_redir_pc_b", redir_pc_b, 32'h10A);
        check("jalr_redir_pc_w", redir_pc_w, 32'h42);
        check("jalr_link_b", ex_link_b, 32'h44);
        check("jalr_redir_v_b", 32'(redir_v_b), 32'h1);
        drive(1'b1, enc_i(12'd1, 5'd0, 3'b000, 5'd5, 7'b0010011), 32'h41);
        tick();
        check("jalr_kill", 32'(ex_valid_b), 32'h0);

        // EX back-pressure for 3 cycles
        drive(1'b1, enc_i(12'd9, 5'd0, 3'b000, 5'd7, 7'b0010011), 32'h50);
        tick();
        ex_ready_i = 1'b0;
        drive(1'b1, enc_i(12'd3, 5'd0, 3'b000, 5'd8, 7'b0010011), 32'h51);
        for (int c = 0; c < 3; c++) begin
            check("bp_ready", 32'(id_ready_w), 32'h0);
            check("bp_hold_rd", 32'(ex_rd_w), 32'h7);
            check("bp_hold_imm", ex_imm_w, 32'h9);
            check("bp_hold_valid", 32'(ex_valid_w), 32'h1);
            tick();
        end
        ex_ready_i = 1'b1;
        #1;
        check("bp_release_ready", 32'(id_ready_w), 32'h1);
        tick();
        check("bp_next_rd", 32'(ex_rd_w), 32'h8);
        check("bp_next_pc", ex_pc_w, 32'h51);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("bp_no_dup", 32'(ex_valid_w), 32'h0);

        // Flush collides with a taken BNE x1,x2
        flush_i = 1'b1;
        drive(1'b1, enc_b(5'd1, 5'd2, 13'd8, 3'b001), 32'h60);
        check("flush_ready", 32'(id_ready_w), 32'h0);
        tick();
        check("flush_no_redir", 32'(redir_v_w), 32'h0);
        check("flush_no_valid", 32'(ex_valid_w), 32'h0);
        flush_i = 1'b0;

        // Reset while stalled on a load-use
        drive(1'b1, enc_i(12'd0, 5'd0, 3'b010, 5'd9, 7'b0000011), 32'h70);
        tick();
        drive(1'b1, enc_r(5'd10, 5'd9, 5'd0), 32'h71);
        check("stall2_ready", 32'(id_ready_w), 32'h0);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(ex_valid_w), 32'h0);
        check("arst_pc", ex_pc_w, 32'h0);
        check("arst_rd", 32'(ex_rd_w), 32'h0);
        check("arst_is_load", 32'(ex_is_load_w), 32'h0);
        check("arst_redir_pc", redir_pc_w, 32'h0);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        drive(1'b1, enc_i(12'd1, 5'd0, 3'b000, 5'd11, 7'b0010011), 32'h80);
        check("arst_run_ready", 32'(id_ready_w), 32'h1);
        tick();
        check("arst_run_pc", ex_pc_w, 32'h80);
        check("arst_run_valid", 32'(ex_valid_w), 32'h1);
        drive(1'b0, 32'h0, 32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
